// File: rtl/scan_sequencer_3b.sv
// Slot scanner driving a 3-to-8 decoder: steps through enabled slots with a per-slot dwell.
// Optional SCAN_PAUSE_EN adds a pause input that freezes the dwell count and slot.
module scan_sequencer_3b #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               wrap,
  output logic               err
`ifdef SCAN_PAUSE_EN
  ,
  input  logic               pause
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nx;
  logic [2:0]         sel_nx;
  logic [2:0]         adv_sel;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic               wrap_nx, err_nx, hold;

  function automatic logic [2:0] first_slot(input logic [7:0] m, input logic d);
    first_slot = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (d && m[i]) first_slot = 3'(i);
      if (!d && m[7-i]) first_slot = 3'(7 - i);
    end
  endfunction

  // Search wraps modulo 8; the eighth candidate is the current slot itself.
  function automatic logic [2:0] next_slot(input logic [2:0] cur, input logic [7:0] m,
                                           input logic d);
    logic [2:0] cand;
    logic       found;
    next_slot = cur;
    found     = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cand = d ? cur - 3'(i) : cur + 3'(i);
      if (!found && m[cand]) begin
        next_slot = cand;
        found     = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    cnt_nx   = cnt;
    wrap_nx  = 1'b0;
    err_nx   = 1'b0;
    adv_sel  = next_slot(sel, mask, dir);
`ifdef SCAN_PAUSE_EN
    hold     = pause;
`else
    hold     = 1'b0;
`endif
    if (stop) begin
      if (state == RUN) state_nx = IDLE;
    end else if (start) begin
      if (mask == 8'h00) begin
        err_nx   = 1'b1;
        state_nx = IDLE;
      end else begin
        state_nx = RUN;
        sel_nx   = first_slot(mask, dir);
        cnt_nx   = dwell;
      end
    end else if (state == RUN && !hold) begin
      if (cnt != '0) begin
        cnt_nx = cnt - DWELL_W'(1);
      end else if (mask == 8'h00) begin
        state_nx = IDLE;
      end else begin
        sel_nx  = adv_sel;
        cnt_nx  = dwell;
        wrap_nx = dir ? (adv_sel >= sel) : (adv_sel <= sel);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 3'd0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      sel_valid <= (state_nx == RUN);
      busy      <= (state_nx == RUN);
      wrap      <= wrap_nx;
      err       <= err_nx;
      cnt       <= cnt_nx;
    end
  end

endmodule
